// File: rtl/decode_operand_fetch.sv
// Decode/operand-fetch stage: 16x16 register file with write-back bypass,
// one-cycle registered issue to execute, forwarding hints, and a HLT freeze.
module decode_operand_fetch #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_val,
  output logic [3:0]  opcode,
  output logic [3:0]  destReg,
  output logic [15:0] srcVal1,
  output logic [15:0] srcVal2,
  output logic [7:0]  memAddr,
  output logic        used1,
  output logic        used2,
  output logic        halted
);

  // Handshake: an instruction transfers on a posedge with instr_valid && instr_ready;
  // instr_ready depends on the state only, never on instr_valid.
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] rf_q [16];
  logic [15:0] rf_d [16];
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  dest_reg_q, dest_reg_d;
  logic [15:0] src_val1_q, src_val1_d;
  logic [15:0] src_val2_q, src_val2_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic        used1_q, used1_d;
  logic        used2_q, used2_d;

  logic        accept;
  logic        prev_writer;
  logic [3:0]  in_op, in_dest, in_src1, in_src2;
  logic [15:0] rd_src1, rd_src2, rd_dest;

  assign in_op   = instr[15:12];
  assign in_dest = instr[11:8];
  assign in_src1 = instr[7:4];
  assign in_src2 = instr[3:0];

  assign instr_ready = (state_q == RUN);
  assign accept      = instr_valid && instr_ready;
  // The issue register itself is the writer tracker; a bubble issues opcode 0.
  assign prev_writer = (opcode_q >= 4'd2) && (opcode_q <= 4'd10);

  always_comb begin
    rd_src1 = rf_q[in_src1];
    rd_src2 = rf_q[in_src2];
    rd_dest = rf_q[in_dest];
    if (wb_en && (wb_reg == in_src1)) rd_src1 = wb_val;
    if (wb_en && (wb_reg == in_src2)) rd_src2 = wb_val;
    if (wb_en && (wb_reg == in_dest)) rd_dest = wb_val;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_reg] = wb_val;

    state_d    = state_q;
    opcode_d   = '0;
    dest_reg_d = '0;
    src_val1_d = '0;
    src_val2_d = '0;
    mem_addr_d = '0;
    used1_d    = 1'b0;
    used2_d    = 1'b0;

    if (accept) begin
      opcode_d   = in_op;
      dest_reg_d = in_dest;
      case (in_op)
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10: begin
          src_val1_d = rd_src1;
          src_val2_d = rd_src2;
          used1_d    = FWD_EN && prev_writer && (in_src1 == dest_reg_q);
          used2_d    = FWD_EN && prev_writer && (in_src2 == dest_reg_q);
        end
        4'd9: begin
          src_val1_d = rd_src1;
          used1_d    = FWD_EN && prev_writer && (in_src1 == dest_reg_q);
        end
        4'd14, 4'd15: begin
          src_val1_d = rd_dest;
          mem_addr_d = instr[7:0];
        end
        default: ;
      endcase
      if (in_op == 4'd1) state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      opcode_q   <= '0;
      dest_reg_q <= '0;
      src_val1_q <= '0;
      src_val2_q <= '0;
      mem_addr_q <= '0;
      used1_q    <= 1'b0;
      used2_q    <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      dest_reg_q <= dest_reg_d;
      src_val1_q <= src_val1_d;
      src_val2_q <= src_val2_d;
      mem_addr_q <= mem_addr_d;
      used1_q    <= used1_d;
      used2_q    <= used2_d;
      for (int i = 0; i < 16; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign opcode  = opcode_q;
  assign destReg = dest_reg_q;
  assign srcVal1 = src_val1_q;
  assign srcVal2 = src_val2_q;
  assign memAddr = mem_addr_q;
  assign used1   = used1_q;
  assign used2   = used2_q;
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_decode_operand_fetch.sv
// Directed bench for decode_operand_fetch; a second instance with FWD_EN=0
// shares the stimulus so the forwarding-disable behaviour can be compared.
module tb_decode_operand_fetch;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [15:0] wb_val;

  logic        instr_ready, n_instr_ready;
  logic [3:0]  opcode, n_opcode;
  logic [3:0]  destReg, n_destReg;
  logic [15:0] srcVal1, n_srcVal1;
  logic [15:0] srcVal2, n_srcVal2;
  logic [7:0]  memAddr, n_memAddr;
  logic        used1, n_used1;
  logic        used2, n_used2;
  logic        halted, n_halted;

  int checks;
  int failures;

  decode_operand_fetch #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
    .opcode(opcode), .destReg(destReg), .srcVal1(srcVal1), .srcVal2(srcVal2),
    .memAddr(memAddr), .used1(used1), .used2(used2), .halted(halted)
  );

  decode_operand_fetch #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(n_instr_ready), .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
    .opcode(n_opcode), .destReg(n_destReg), .srcVal1(n_srcVal1), .srcVal2(n_srcVal2),
    .memAddr(n_memAddr), .used1(n_used1), .used2(n_used2), .halted(n_halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic we,
                       input logic [3:0] wr, input logic [15:0] wv);
    instr_valid = v;
    instr       = ins;
    wb_en       = we;
    wb_reg      = wr;
    wb_val      = wv;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 16'h2534, 1'b1, 4'd3, 16'hFFFF);
    tick();
    checks++; if ({opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2} !== 50'd0) begin failures++; $display("FAIL reset_issue got=%h exp=0", {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2}); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    // first edge out of reset accepts; R3 write during reset must have been dropped
    rst = 1'b1;
    drive(1'b1, 16'h2330, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if (opcode !== 4'd2) begin failures++; $display("FAIL reset_first_accept_opcode got=%h exp=2", opcode); end
    checks++; if (srcVal1 !== 16'h0000) begin failures++; $display("FAIL reset_wb_dropped got=%h exp=0000", srcVal1); end
  endtask

  task automatic test_alu();
    drive(1'b0, 16'h0000, 1'b1, 4'd3, 16'h0005);
    tick();
    drive(1'b0, 16'h0000, 1'b1, 4'd4, 16'h0007);
    tick();
    drive(1'b1, 16'h2534, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if (opcode !== 4'd2) begin failures++; $display("FAIL alu_opcode got=%h exp=2", opcode); end
    checks++; if (destReg !== 4'd5) begin failures++; $display("FAIL alu_dest got=%h exp=5", destReg); end
    checks++; if (srcVal1 !== 16'h0005) begin failures++; $display("FAIL alu_src1 got=%h exp=0005", srcVal1); end
    checks++; if (srcVal2 !== 16'h0007) begin failures++; $display("FAIL alu_src2 got=%h exp=0007", srcVal2); end
    checks++; if ({memAddr, used1, used2} !== 10'd0) begin failures++; $display("FAIL alu_mem_used got=%h exp=0", {memAddr, used1, used2}); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h2534, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({used1, used2} !== 2'b00) begin failures++; $display("FAIL b2b_first_used got=%b exp=00", {used1, used2}); end
    drive(1'b1, 16'h3656, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({opcode, destReg} !== 8'h36) begin failures++; $display("FAIL b2b_sub_opdest got=%h exp=36", {opcode, destReg}); end
    checks++; if ({used1, used2} !== 2'b10) begin failures++; $display("FAIL b2b_sub_used got=%b exp=10", {used1, used2}); end
    checks++; if ({n_used1, n_used2} !== 2'b00) begin failures++; $display("FAIL b2b_nofwd_used got=%b exp=00", {n_used1, n_used2}); end
    drive(1'b1, 16'h4766, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({used1, used2} !== 2'b11) begin failures++; $display("FAIL b2b_and_used got=%b exp=11", {used1, used2}); end
    checks++; if (n_used2 !== 1'b0) begin failures++; $display("FAIL b2b_nofwd_used2 got=%b exp=0", n_used2); end
    drive(1'b1, 16'h9870, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({opcode, used1, used2} !== 6'b1001_10) begin failures++; $display("FAIL b2b_not_used got=%b exp=100110", {opcode, used1, used2}); end
    checks++; if (srcVal2 !== 16'h0000) begin failures++; $display("FAIL b2b_not_src2 got=%h exp=0000", srcVal2); end
    drive(1'b1, 16'hE812, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({opcode, memAddr} !== 12'hE12) begin failures++; $display("FAIL b2b_load_opmem got=%h exp=e12", {opcode, memAddr}); end
    checks++; if ({used1, used2} !== 2'b00) begin failures++; $display("FAIL b2b_load_used got=%b exp=00", {used1, used2}); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 16'h7122, 1'b1, 4'd2, 16'hABCD);
    tick();
    checks++; if (srcVal1 !== 16'hABCD) begin failures++; $display("FAIL bypass_src1 got=%h exp=abcd", srcVal1); end
    checks++; if (srcVal2 !== 16'hABCD) begin failures++; $display("FAIL bypass_src2 got=%h exp=abcd", srcVal2); end
    checks++; if ({used1, used2} !== 2'b00) begin failures++; $display("FAIL bypass_used got=%b exp=00", {used1, used2}); end
    drive(1'b1, 16'h7122, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({srcVal1, srcVal2} !== 32'hABCD_ABCD) begin failures++; $display("FAIL bypass_committed got=%h exp=abcdabcd", {srcVal1, srcVal2}); end
  endtask

  task automatic test_bubble();
    drive(1'b1, 16'h2534, 1'b0, 4'd0, 16'h0000);
    tick();
    drive(1'b0, 16'h3656, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2} !== 50'd0) begin failures++; $display("FAIL bubble_issue got=%h exp=0", {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2}); end
    drive(1'b1, 16'h3656, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({opcode, used1} !== 5'b0011_0) begin failures++; $display("FAIL bubble_sub got=%b exp=00110", {opcode, used1}); end
    drive(1'b1, 16'hB626, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({opcode, destReg} !== 8'hB6) begin failures++; $display("FAIL misc_opdest got=%h exp=b6", {opcode, destReg}); end
    checks++; if ({srcVal1, srcVal2, memAddr, used1, used2} !== 42'd0) begin failures++; $display("FAIL misc_zero got=%h exp=0", {srcVal1, srcVal2, memAddr, used1, used2}); end
  endtask

  task automatic test_load_halt();
    drive(1'b0, 16'h0000, 1'b1, 4'd9, 16'h1234);
    tick();
    drive(1'b1, 16'hE912, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if ({opcode, destReg, memAddr} !== 16'hE912) begin failures++; $display("FAIL load_fields got=%h exp=e912", {opcode, destReg, memAddr}); end
    checks++; if ({srcVal1, srcVal2} !== 32'h1234_0000) begin failures++; $display("FAIL load_src got=%h exp=12340000", {srcVal1, srcVal2}); end
    checks++; if ({used1, used2} !== 2'b00) begin failures++; $display("FAIL load_used got=%b exp=00", {used1, used2}); end
    drive(1'b1, 16'h1000, 1'b0, 4'd0, 16'h0000);
    tick();
    checks++; if (opcode !== 4'd1) begin failures++; $display("FAIL hlt_opcode got=%h exp=1", opcode); end
    checks++; if ({halted, instr_ready} !== 2'b10) begin failures++; $display("FAIL hlt_state got=%b exp=10", {halted, instr_ready}); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h2534, 1'b1, 4'd10, 16'h5555);
      tick();
      checks++; if ({opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2} !== 50'd0) begin failures++; $display("FAIL halt_nop%0d got=%h exp=0", i, {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2}); end
      checks++; if ({halted, instr_ready} !== 2'b10) begin failures++; $display("FAIL halt_hold%0d got=%b exp=10", i, {halted, instr_ready}); end
    end
  endtask

  task automatic test_reset_from_halt();
    rst = 1'b0;
    drive(1'b1, 16'h2534, 1'b0, 4'd0, 16'h0000);
    tick();
    rst = 1'b1;
    checks++; if ({opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2} !== 50'd0) begin failures++; $display("FAIL rst_halt_issue got=%h exp=0", {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2}); end
    checks++; if ({halted, instr_ready} !== 2'b01) begin failures++; $display("FAIL rst_halt_state got=%b exp=01", {halted, instr_ready}); end
    for (int k = 0; k < 8; k++) begin
      logic [3:0] a;
      logic [3:0] b;
      a = 4'(2 * k);
      b = 4'(2 * k + 1);
      drive(1'b1, {4'h2, 4'h0, a, b}, 1'b0, 4'd0, 16'h0000);
      tick();
      checks++; if ({opcode, srcVal1, srcVal2} !== 36'h2_0000_0000) begin failures++; $display("FAIL rf_cleared r%0d/r%0d got=%h exp=200000000", a, b, {opcode, srcVal1, srcVal2}); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    tick();
    test_reset();
    test_alu();
    test_back_to_back();
    test_bypass();
    test_bubble();
    test_load_halt();
    test_reset_from_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
